// File: rtl/edge_line_writer.sv
// Purpose : buffers 64-bit edge lines from the coprocessor and writes each one into the
//           32-bit result RAM as a low word then a high word; signals frame completion.
// Latency : strobe seen at cycle 0 -> pop cycle 1 -> low word visible cycle 3, high cycle 4.
// Backpr. : writes stall while ram_grant=0; the FIFO absorbs lines and drops one when full
//           (sticky overflow).
// Ports   : clk_50M/reset (sync, active-low); base_addr, line_strobe, line_pixels,
//           line_index, src_done, ram_grant in; ram_wraddress, ram_data, ram_wren, busy,
//           frame_done, overflow, lines_written out.
module edge_line_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12,
    parameter int LINE_W     = 64,
    parameter int WORD_W     = 32
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              line_strobe,
    input  logic [LINE_W-1:0] line_pixels,
    input  logic [ADDR_W-1:0] line_index,
    input  logic              src_done,
    input  logic              ram_grant,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [WORD_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] lines_written
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + LINE_W;

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;

    state_t             state, state_n;
    logic               strobe_q, done_q, done_pend, clr_pend;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               push_req, push, pop;
    logic               wr_lo_fire, wr_hi_fire;
    logic [ENTRY_W-1:0] fifo_rd;
    logic [ADDR_W-1:0]  pop_idx;
    logic [LINE_W-1:0]  pop_pix;
    logic [LINE_W-1:0]  hold_pix;
    logic [ADDR_W-1:0]  wa;

    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A strobe arriving while full is dropped even if a pop frees a slot this cycle.
    assign push_req   = line_strobe & ~strobe_q;
    assign push       = push_req & ~fifo_full;
    assign fifo_rd    = fifo_mem[rd_ptr];
    assign pop_idx    = fifo_rd[ENTRY_W-1:LINE_W];
    assign pop_pix    = fifo_rd[LINE_W-1:0];

    assign busy       = ~fifo_empty | (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        wr_lo_fire = 1'b0;
        wr_hi_fire = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = WR_LO;
                end else if (done_pend) begin
                    state_n = DONE;
                end
            end
            WR_LO: begin
                if (ram_grant) begin
                    wr_lo_fire = 1'b1;
                    state_n    = WR_HI;
                end
            end
            WR_HI: begin
                if (ram_grant) begin
                    wr_hi_fire = 1'b1;
                    // Chain straight into the next line to sustain one line per two cycles.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = WR_LO;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_50M) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {line_index, line_pixels};
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            state         <= IDLE;
            strobe_q      <= 1'b0;
            done_q        <= 1'b0;
            done_pend     <= 1'b0;
            clr_pend      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            hold_pix      <= '0;
            wa            <= '0;
            ram_wraddress <= '0;
            ram_data      <= '0;
            ram_wren      <= 1'b0;
            overflow      <= 1'b0;
            lines_written <= '0;
        end else begin
            state    <= state_n;
            strobe_q <= line_strobe;
            done_q   <= src_done;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_req && fifo_full) overflow <= 1'b1;

            if (pop) begin
                hold_pix <= pop_pix;
                wa       <= base_addr + {pop_idx[ADDR_W-2:0], 1'b0};
            end

            ram_wren <= wr_lo_fire | wr_hi_fire;
            if (wr_lo_fire) begin
                ram_wraddress <= wa;
                ram_data      <= hold_pix[WORD_W-1:0];
            end else if (wr_hi_fire) begin
                ram_wraddress <= wa + ADDR_W'(1);
                ram_data      <= hold_pix[LINE_W-1:WORD_W];
            end

            // Count restarts with the first line of the next frame.
            if (push_req && clr_pend) begin
                lines_written <= wr_hi_fire ? ADDR_W'(1) : '0;
                clr_pend      <= 1'b0;
            end else if (wr_hi_fire) begin
                lines_written <= lines_written + ADDR_W'(1);
            end
            if (state == DONE) clr_pend <= 1'b1;

            if (state == DONE)        done_pend <= 1'b0;
            if (src_done && !done_q)  done_pend <= 1'b1;
        end
    end

endmodule
